spi_reg_ctrl: RTL and testbench

- Command/register sequencer that sits behind the beacon FPGA's SPI slave byte engine and turns its byte stream into register-file accesses.
- Decodes the first byte of each SS frame as a command: read/write bit plus start address. Then streams write data into the register file, or prefetches read data onto the slave's transmit byte, with address auto-increment.
- Also drives frame bookkeeping (busy, frame counter, error strobe) for the ESP32-side link.

---
 rtl/spi_ctrl_pkg.sv | 23 ++
 rtl/spi_reg_ctrl_sync_edge.sv | 35 +++
 rtl/spi_reg_ctrl.sv | 143 ++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: shared state encoding, command-byte field positions and defaults for spi_reg_ctrl
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_RD_FETCH,
        S_RD_WAIT,
        S_RD_STREAM,
        S_WR_STREAM
    } state_t;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_ADDR_W = 7;

    // Command byte layout: {rw, addr[ADDR_W-1:0]}
    localparam int RW_BIT   = DEF_WIDTH - 1;
    localparam int ADDR_MSB = DEF_ADDR_W - 1;
    localparam int ADDR_LSB = 0;

    localparam logic [DEF_WIDTH-1:0] DEF_IDLE_BYTE = 8'hA5;

endpackage

// File: rtl/spi_reg_ctrl_sync_edge.sv
// sync_edge: 2-flop synchroniser with rise/fall strobes.
//   clk, rst_n : clock, async active-low reset (all flops reset to RST_VAL)
//   d          : asynchronous input
//   q          : synchronised level
//   rise, fall : one-cycle strobes on synchronised edges
module sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta, sync, prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign q    = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns the SPI slave byte stream into register-file reads/writes.
//   clk, rst_n          : clock, async active-low reset
//   ss_n                : raw slave select (async)
//   byte_done, rx_byte  : slave byte-complete level and received byte
//   tx_byte             : next byte for the slave to shift out
//   reg_addr/wdata/we/re, reg_rdata : register-file access port
//   busy, frame_cnt, err: frame bookkeeping
module spi_reg_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int                WIDTH     = DEF_WIDTH,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                NUM_REGS  = 64,
    parameter int                READ_LAT  = 1,
    parameter logic [WIDTH-1:0]  IDLE_BYTE = DEF_IDLE_BYTE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ss_n,
    input  logic              byte_done,
    input  logic [WIDTH-1:0]  rx_byte,
    output logic [WIDTH-1:0]  tx_byte,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [WIDTH-1:0]  reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [WIDTH-1:0]  reg_rdata,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic              err
);

    localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);
    localparam logic [1:0]      LAT   = 2'(READ_LAT);

    state_t            state, state_n;
    logic              ss_sync, ss_rise, ss_fall;
    logic              byte_done_q, byte_ev, oor;
    logic              cmd_seen, cmd_seen_n, wr_inc, wr_inc_n;
    logic [1:0]        cnt, cnt_n;
    logic [WIDTH-1:0]  tx_n, wdata_n;
    logic [ADDR_W-1:0] addr_n;
    logic              we_n, re_n, err_n;
    logic [15:0]       fcnt_n;

    sync_edge #(.RST_VAL(1'b1)) u_ss (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (ss_n),
        .q    (ss_sync),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    assign busy    = ~ss_sync;
    assign byte_ev = byte_done & ~byte_done_q;
    assign oor     = {1'b0, reg_addr} >= NREGS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            byte_done_q <= 1'b1;
            tx_byte     <= IDLE_BYTE;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            err         <= 1'b0;
            frame_cnt   <= '0;
            cmd_seen    <= 1'b0;
            wr_inc      <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_n;
            byte_done_q <= byte_done;
            tx_byte     <= tx_n;
            reg_addr    <= addr_n;
            reg_wdata   <= wdata_n;
            reg_we      <= we_n;
            reg_re      <= re_n;
            err         <= err_n;
            frame_cnt   <= fcnt_n;
            cmd_seen    <= cmd_seen_n;
            wr_inc      <= wr_inc_n;
            cnt         <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        tx_n       = tx_byte;
        // a write strobe is issued at the current address; the bump follows a cycle later
        addr_n     = wr_inc ? reg_addr + 1'b1 : reg_addr;
        wdata_n    = reg_wdata;
        we_n       = 1'b0;
        re_n       = 1'b0;
        err_n      = 1'b0;
        fcnt_n     = frame_cnt;
        cmd_seen_n = cmd_seen;
        wr_inc_n   = 1'b0;
        cnt_n      = cnt + 1'b1;
        case (state)
            S_IDLE: if (ss_fall) state_n = S_CMD;
            S_CMD: if (byte_ev) begin
                addr_n     = rx_byte[ADDR_W-1:0];
                cmd_seen_n = 1'b1;
                state_n    = rx_byte[WIDTH-1] ? S_RD_FETCH : S_WR_STREAM;
            end
            S_RD_FETCH: begin
                // out-of-range reads never reach the register file
                re_n    = ~oor;
                cnt_n   = '0;
                state_n = S_RD_WAIT;
            end
            S_RD_WAIT: if (cnt == LAT) begin
                tx_n    = oor ? IDLE_BYTE : reg_rdata;
                err_n   = oor;
                state_n = S_RD_STREAM;
            end
            S_RD_STREAM: if (byte_ev) begin
                addr_n  = reg_addr + 1'b1;
                state_n = S_RD_FETCH;
            end
            S_WR_STREAM: if (byte_ev) begin
                wdata_n  = rx_byte;
                we_n     = ~oor;
                err_n    = oor;
                wr_inc_n = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        // frame end wins over everything except a write landing in the same cycle
        if (ss_rise) begin
            state_n    = S_IDLE;
            tx_n       = IDLE_BYTE;
            re_n       = 1'b0;
            err_n      = (state == S_WR_STREAM) & err_n;
            fcnt_n     = frame_cnt + {15'd0, cmd_seen_n};
            cmd_seen_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

    localparam int SCK = 16;
    localparam int K_W = 0, K_R = 1, K_E = 2;

    logic        clk = 1'b0, rst_n = 1'b0, ss_n = 1'b1, byte_done = 1'b0;
    logic [7:0]  rx_byte = 8'h00, tx_byte, reg_wdata, reg_rdata, rdq;
    logic [6:0]  reg_addr;
    logic        reg_we, reg_re, busy, err;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    spi_reg_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ss_n     (ss_n),
        .byte_done(byte_done),
        .rx_byte  (rx_byte),
        .tx_byte  (tx_byte),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_rdata(reg_rdata),
        .busy     (busy),
        .frame_cnt(frame_cnt),
        .err      (err)
    );

    // register file seen by the DUT, one cycle read latency
    logic [7:0] regs [64];
    assign reg_rdata = rdq;
    always @(posedge clk) begin
        if (reg_we && !reg_addr[6]) regs[reg_addr[5:0]] <= reg_wdata;
        if (reg_re) rdq <= regs[reg_addr[5:0]];
    end

    int n_cmp = 0, n_bad = 0;

    function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endfunction

    // reference model: expected strobe sequence, expected MISO bytes, register contents, frame count
    typedef struct {int kind; int addr; int data;} ev_t;
    ev_t        exp_q[$];
    ev_t        ev;
    logic [7:0] mm [64];
    int         fcnt = 0;
    logic [7:0] fb [8];
    logic [7:0] xmiso [8];
    logic [7:0] miso [8];

    function automatic void model_frame(int n);
        int a0, a;
        a0 = int'(fb[0][6:0]);
        for (int j = 0; j < 8; j++) xmiso[j] = 8'hA5;
        if (fb[0][7]) begin
            for (int k = 0; k < n; k++) begin
                a = (a0 + k) % 128;
                if (a < 64) begin
                    exp_q.push_back('{K_R, a, 0});
                    if (k + 2 < n) xmiso[k+2] = mm[a];
                end else exp_q.push_back('{K_E, a, 0});
            end
        end else begin
            for (int i = 1; i < n; i++) begin
                a = (a0 + i - 1) % 128;
                if (a < 64) begin
                    exp_q.push_back('{K_W, a, int'(fb[i])});
                    mm[a] = fb[i];
                end else exp_q.push_back('{K_E, a, 0});
            end
        end
        if (n > 0) fcnt = (fcnt + 1) % 65536;
    endfunction

    always @(negedge clk) if (rst_n) begin
        chk("we_re_excl", {31'd0, reg_we & reg_re}, 32'd0);
        if (reg_we || reg_re || err) begin
            if (exp_q.size() == 0) chk("unexpected_strobe", {29'd0, reg_we, reg_re, err}, 32'd0);
            else begin
                ev = exp_q.pop_front();
                chk("strobe_kind", reg_we ? K_W : reg_re ? K_R : K_E, ev.kind);
                chk("strobe_addr", {25'd0, reg_addr}, ev.addr);
                if (ev.kind == K_W) chk("strobe_wdata", {24'd0, reg_wdata}, ev.data);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(int i, bit coincide);
        logic [7:0] mid;
        tick(SCK * 7);
        mid = tx_byte;
        tick(SCK);
        miso[i+1] = tx_byte;
        chk("tx_stable", {24'd0, tx_byte}, {24'd0, mid});
        if (coincide) begin
            ss_n = 1'b1;
            tick(2);
        end
        rx_byte   = fb[i];
        byte_done = 1'b1;
        tick(4);
        byte_done = 1'b0;
    endtask

    task automatic end_checks(int n);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("tx_idle", {24'd0, tx_byte}, 32'hA5);
        chk("frame_cnt", {16'd0, frame_cnt}, fcnt);
        chk("events_left", exp_q.size(), 32'd0);
        for (int j = 0; j < n; j++) chk("miso", {24'd0, miso[j]}, {24'd0, xmiso[j]});
        exp_q.delete();
    endtask

    task automatic run_frame(int n, bit coincide);
        model_frame(n);
        ss_n = 1'b0;
        tick(6);
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        miso[0] = tx_byte;
        for (int i = 0; i < n; i++) send_byte(i, coincide && i == n - 1);
        tick(10);
        ss_n = 1'b1;
        tick(6);
        end_checks(n);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        int n;
        bit co;
        for (int i = 0; i < 64; i++) begin
            v = 8'($urandom);
            regs[i] <= v;
            mm[i] = v;
        end
        tick(3);
        chk("rst_tx", {24'd0, tx_byte}, 32'hA5);
        chk("rst_addr", {25'd0, reg_addr}, 32'd0);
        chk("rst_we_re_err", {29'd0, reg_we, reg_re, err}, 32'd0);
        chk("rst_busy_cnt", {15'd0, busy, frame_cnt}, 32'd0);
        rst_n = 1'b1;
        tick(3);

        fb[0] = 8'h05; fb[1] = 8'h11; fb[2] = 8'h22;
        run_frame(3, 1'b0);
        chk("t1_cnt", {16'd0, frame_cnt}, 32'd1);
        chk("t1_reg5", {24'd0, regs[5]}, 32'h11);
        chk("t1_reg6", {24'd0, regs[6]}, 32'h22);

        fb[0] = 8'h10; fb[1] = 8'h3C; fb[2] = 8'h7E;
        run_frame(3, 1'b0);
        fb[0] = 8'h90; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00;
        run_frame(4, 1'b0);
        chk("t2_miso1", {24'd0, miso[1]}, 32'hA5);
        chk("t2_miso2", {24'd0, miso[2]}, 32'h3C);
        chk("t2_miso3", {24'd0, miso[3]}, 32'h7E);

        fb[0] = 8'h3F; fb[1] = 8'h01; fb[2] = 8'h02;
        run_frame(3, 1'b0);
        chk("t3_reg63", {24'd0, regs[63]}, 32'h01);

        fb[0] = 8'h00; fb[1] = 8'h5A;
        run_frame(2, 1'b0);
        fb[0] = 8'hFF; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00;
        run_frame(4, 1'b0);
        chk("t4_miso2", {24'd0, miso[2]}, 32'hA5);
        chk("t4_miso3", {24'd0, miso[3]}, 32'h5A);

        // abort three SCK bits into the command byte
        ss_n = 1'b0;
        tick(6 + 3 * SCK);
        ss_n = 1'b1;
        tick(6);
        chk("abort_cnt", {16'd0, frame_cnt}, 32'd6);
        chk("abort_busy", {31'd0, busy}, 32'd0);

        // frame end lands in the same cycle as the last write byte
        fb[0] = 8'h20; fb[1] = 8'hAB; fb[2] = 8'hCD;
        run_frame(3, 1'b1);
        chk("t5_reg21", {24'd0, regs[33]}, 32'hCD);
        chk("t5_cnt", {16'd0, frame_cnt}, 32'd7);

        // async reset in the middle of a read stream
        fb[0] = 8'h90; fb[1] = 8'h00;
        model_frame(2);
        ss_n = 1'b0;
        tick(6);
        send_byte(0, 1'b0);
        send_byte(1, 1'b0);
        tick(SCK * 3);
        chk("t6_pre_tx", {24'd0, tx_byte}, 32'h7E);
        chk("t6_events_left", exp_q.size(), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_tx", {24'd0, tx_byte}, 32'hA5);
        chk("t6_addr_wdata", {17'd0, reg_addr, reg_wdata}, 32'd0);
        chk("t6_strobes", {29'd0, reg_we, reg_re, err}, 32'd0);
        chk("t6_busy_cnt", {15'd0, busy, frame_cnt}, 32'd0);
        exp_q.delete();
        fcnt = 0;
        ss_n = 1'b1;
        byte_done = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        fb[0] = 8'h90; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00;
        run_frame(4, 1'b0);
        chk("t6_post_miso2", {24'd0, miso[2]}, 32'h3C);
        chk("t6_post_miso3", {24'd0, miso[3]}, 32'h7E);
        chk("t6_post_cnt", {16'd0, frame_cnt}, 32'd1);

        for (int f = 0; f < 14; f++) begin
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < 8; i++) fb[i] = 8'($urandom);
            co = !fb[0][7] && n > 1 && ($urandom % 4 == 0);
            run_frame(n, co);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
